// File: rtl/sipo_word_receiver.sv
// Serial-in, parallel-out word receiver: assembles WIDTH-bit words from strobed bits
// and presents them in a holding register behind a valid/ready handshake.
module sipo_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_d,
  input  logic                     i_shift,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_overrun,
  output logic [$clog2(WIDTH)-1:0] o_bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic             complete;
  logic             transfer;

  // next_word is the shift register after absorbing i_d; on completion it is the full word
  always_comb begin
    next_word = '0;
    if (MSB_FIRST) next_word = {shift_reg[WIDTH-2:0], i_d};
    else           next_word = {i_d, shift_reg[WIDTH-1:1]};
  end

  assign complete = i_shift && !i_clr && (o_bit_cnt == LAST_BIT);
  assign transfer = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_reg <= '0;
      o_bit_cnt <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (i_clr) begin
        shift_reg <= '0;
        o_bit_cnt <= '0;
        o_overrun <= 1'b0;
      end else if (i_shift) begin
        if (complete) begin
          shift_reg <= '0;
          o_bit_cnt <= '0;
        end else begin
          shift_reg <= next_word;
          o_bit_cnt <= o_bit_cnt + 1'b1;
        end
      end

      // A transfer on the completing edge frees the slot, so the new word is not lost
      if (complete) begin
        if (!o_valid || transfer) begin
          o_data  <= next_word;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (transfer) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sipo_word_receiver.md
# sipo_word_receiver

Serial-in, parallel-out word receiver that sits directly downstream of the team's parallel-in serial-out shifter. It samples one serial bit per qualified clock, assembles WIDTH-bit words with a bit counter, and presents each completed word in a holding register behind a valid/ready handshake. A sticky overrun flag reports words dropped because the consumer did not drain the holding register in time.

## Interface
- WIDTH, 4, word length in bits (≥2)
- MSB_FIRST, 1, 1: first received bit lands in o_data[WIDTH-1]; 0: first bit lands in o_data[0]

- i_clk  input  1  clock; all state changes on the rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_d  input  1  serial data bit
- i_shift  input  1  bit strobe; i_d is sampled on edges where i_shift=1
- i_clr  input  1  abort the partial word and clear overrun
- o_data  output  WIDTH  holding register, the last completed word
- o_valid  output  1  o_data holds an unconsumed word
- i_ready  input  1  consumer accepts o_data when o_valid=1 and i_ready=1
- o_overrun  output  1  sticky: a completed word was dropped
- o_bit_cnt  output  $clog2(WIDTH)  bits collected in the current partial word

## Operation
- Reset (i_rst=1 at an edge): shift register=0, o_bit_cnt=0, o_data=0, o_valid=0, o_overrun=0. Reset overrides every other input, including mid-word and mid-handshake.
- Priority at each edge: i_rst > i_clr > i_shift.
- i_clr=1: shift register=0, o_bit_cnt=0, o_overrun=0. Any i_shift bit in the same cycle is discarded. o_data and o_valid are unaffected, and a handshake in the same cycle still completes.
- Collect: on i_shift=1, the bit enters the shift register (MSB_FIRST=1 shifts left with i_d in bit 0; MSB_FIRST=0 shifts right with i_d in bit WIDTH-1). o_bit_cnt increments.
- Completion: the strobe with o_bit_cnt=WIDTH-1 completes a word. The full word, including the current bit, is the candidate. o_bit_cnt wraps to 0 and the shift register clears.
- Handshake: a transfer occurs on an edge where o_valid=1 and i_ready=1. i_ready is ignored while o_valid=0.
- Holding register update, evaluated at the edge:
  - Completion with o_valid=0: o_data←word, o_valid←1.
  - Completion in the same cycle as a transfer: o_data←new word, o_valid stays 1. No loss.
  - Completion with o_valid=1 and no transfer: the new word is dropped, o_data keeps the old word, o_overrun←1.
  - Transfer without completion: o_valid←0 and o_data holds its value.
- o_overrun stays set until i_rst or i_clr.
- Idle cycles (i_shift=0) between bits are allowed and do not disturb the partial word.

## Timing
- Every output is registered. Nothing is combinational from input to output.
- Latency: o_data and o_valid update on the same edge that samples the WIDTH-th bit. Back-to-back strobes give one word per WIDTH cycles.
- With i_ready held at 1, o_valid is a one-cycle pulse per word when words are spaced by at least one gap cycle. With continuous strobing it is a WIDTH-cycle-apart pulse.
- A consumer that asserts i_ready within WIDTH-1 cycles after o_valid rises never causes an overrun under continuous strobing.
- o_bit_cnt reads 0..WIDTH-1 and never reads WIDTH.

## Test plan
- Reset then idle: i_rst=1 for one edge with i_shift=0 → o_data=0, o_valid=0, o_overrun=0, o_bit_cnt=0, holding for 10 cycles.
- MSB-first word, WIDTH=4: strobe bits 1,0,1,0 on consecutive edges, i_ready=1 → o_data=4'b1010 and o_valid=1 on the 4th edge, o_valid=0 one edge later. Repeat with MSB_FIRST=0 → o_data=4'b0101.
- Back-pressure and overrun: i_ready=0, send 4'b1100 then 4'b0011 → o_data stays 4'b1100, o_valid=1, o_overrun=1. Then i_ready=1 → o_valid drops after one edge.
- Same-cycle completion and transfer: o_valid=1 holding 4'b1111, i_ready=1 raised on the edge completing 4'b0110 → o_data=4'b0110, o_valid stays 1, o_overrun=0.
- Abort mid-word: strobe 1,1, then i_clr=1 with i_shift=1, then strobe 0,0,0,1 → o_bit_cnt=0 after the clear, completed word=4'b0001, o_overrun=0.
- Reset mid-operation: i_rst=1 after 2 bits while o_valid=1 → all outputs return to 0. The next 4 strobed bits form a clean word.
